// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 power-up / init-table sequencer.
// Holds the state encoding, the reserved register addresses that mark
// table control entries, and the camera-select codes.
package ov5640_cfg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST_HOLD,
      ST_POST_WAIT,
      ST_FETCH,
      ST_DECODE,
      ST_REQ,
      ST_ACK_LOW,
      ST_ACK_HIGH,
      ST_DELAY,
      ST_DONE,
      ST_ERROR
   } state_t;

   // Reserved register addresses in the init table
   localparam logic [15:0] REG_END   = 16'hFFFE;
   localparam logic [15:0] REG_DELAY = 16'hFFFF;

   // Camera select codes
   localparam logic [1:0] CAM_BOTH = 2'b00;
   localparam logic [1:0] CAM0     = 2'b01;
   localparam logic [1:0] CAM1     = 2'b10;
   localparam logic [1:0] CAM_NONE = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk / rst_n (async, active-low, output clears to 0),
//        d (asynchronous input), q (synchronized output).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ov5640_init_sequencer.sv
// OV5640 power-up and register-table sequencer.
// Sequences PWDN/RESETB, walks a synchronous init ROM of {addr,data} entries
// and hands each write to the SCCB writer over a 4-phase start/ready handshake.
// Ports: xclk_cam/reset_n clock and async reset; start_cfg/cam_sel request;
//        rom_addr/rom_data init ROM; sccb_* writer handshake and payload;
//        select_initial_cam, PWDN, RESETB camera controls; cfg_* status;
//        entries_done count of completed writes.
module ov5640_init_sequencer
   import ov5640_cfg_pkg::*;
#(
   parameter int unsigned ROM_AW          = 8,
   parameter int unsigned RESET_HOLD      = 2500,
   parameter int unsigned POST_RESET_WAIT = 480000,
   parameter int unsigned DELAY_UNIT      = 24000,
   parameter int unsigned ACK_TIMEOUT     = 65535
) (
   input  logic              xclk_cam,
   input  logic              reset_n,
   input  logic              start_cfg,
   input  logic [1:0]        cam_sel,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              sccb_start,
   output logic [15:0]       sccb_address,
   output logic [7:0]        sccb_data,
   input  logic              sccb_ready,
   output logic [1:0]        select_initial_cam,
   output logic              PWDN,
   output logic              RESETB,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_error,
   output logic [ROM_AW:0]   entries_done
);

   // One shared counter serves reset hold, post-reset wait, delay units and timeouts
   localparam int unsigned MAX_A   = (RESET_HOLD > POST_RESET_WAIT) ? RESET_HOLD : POST_RESET_WAIT;
   localparam int unsigned MAX_B   = (DELAY_UNIT > ACK_TIMEOUT) ? DELAY_UNIT : ACK_TIMEOUT;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       ticks;
   logic [7:0]       tick_target;
   logic             ready_s;
   logic             last_entry_c;

   sync_2ff u_ready_sync (
      .clk   (xclk_cam),
      .rst_n (reset_n),
      .d     (sccb_ready),
      .q     (ready_s)
   );

   // Table never wraps: the final ROM slot ends the run
   assign last_entry_c = (rom_addr == {ROM_AW{1'b1}});

   always_ff @(posedge xclk_cam or negedge reset_n) begin
      if (!reset_n) begin
         state              <= ST_IDLE;
         cnt                <= '0;
         ticks              <= '0;
         tick_target        <= '0;
         rom_addr           <= '0;
         sccb_start         <= 1'b0;
         sccb_address       <= '0;
         sccb_data          <= '0;
         select_initial_cam <= CAM_NONE;
         PWDN               <= 1'b1;
         RESETB             <= 1'b0;
         cfg_busy           <= 1'b0;
         cfg_done           <= 1'b0;
         cfg_error          <= 1'b0;
         entries_done       <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_cfg) begin
                  cnt      <= '0;
                  cfg_done <= 1'b0;
                  if (cam_sel == CAM_NONE) begin
                     cfg_error <= 1'b1;
                     state     <= ST_ERROR;
                  end else begin
                     select_initial_cam <= cam_sel;
                     cfg_error          <= 1'b0;
                     entries_done       <= '0;
                     rom_addr           <= '0;
                     PWDN               <= 1'b0;
                     RESETB             <= 1'b0;
                     cfg_busy           <= 1'b1;
                     state              <= ST_RST_HOLD;
                  end
               end
            end
            ST_RST_HOLD: begin
               if (cnt == CNT_W'(RESET_HOLD - 1)) begin
                  RESETB <= 1'b1;
                  cnt    <= '0;
                  state  <= ST_POST_WAIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_POST_WAIT: begin
               if (cnt == CNT_W'(POST_RESET_WAIT - 1)) begin
                  cnt   <= '0;
                  state <= ST_FETCH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FETCH: begin
               cnt   <= '0;
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               cnt <= '0;
               if (rom_data[23:8] == REG_END) begin
                  cfg_busy <= 1'b0;
                  cfg_done <= 1'b1;
                  state    <= ST_DONE;
               end else if (rom_data[23:8] == REG_DELAY) begin
                  tick_target <= rom_data[7:0];
                  ticks       <= '0;
                  state       <= ST_DELAY;
               end else begin
                  // Payload loads here and start rises on entry to REQ
                  sccb_address <= rom_data[23:8];
                  sccb_data    <= rom_data[7:0];
                  sccb_start   <= 1'b1;
                  state        <= ST_REQ;
               end
            end
            ST_REQ: begin
               cnt   <= '0;
               state <= ST_ACK_LOW;
            end
            ST_ACK_LOW: begin
               if (!ready_s) begin
                  sccb_start <= 1'b0;
                  cnt        <= '0;
                  state      <= ST_ACK_HIGH;
               end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  sccb_start <= 1'b0;
                  cfg_busy   <= 1'b0;
                  cfg_error  <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_ERROR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_ACK_HIGH: begin
               cnt <= '0;
               if (ready_s) begin
                  entries_done <= entries_done + 1'b1;
                  if (last_entry_c) begin
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     state    <= ST_FETCH;
                  end
               end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  cfg_busy  <= 1'b0;
                  cfg_error <= 1'b1;
                  state     <= ST_ERROR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DELAY: begin
               // cnt counts cycles within one tick; ticks counts elapsed ticks
               if (ticks == tick_target) begin
                  cnt <= '0;
                  if (last_entry_c) begin
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     state    <= ST_FETCH;
                  end
               end else if (cnt == CNT_W'(DELAY_UNIT - 1)) begin
                  cnt   <= '0;
                  ticks <= ticks + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Self-checking bench for ov5640_init_sequencer with a ROM model, an SCCB
// writer model and a scoreboard of expected register writes.
module tb_ov5640_init_sequencer;
   import ov5640_cfg_pkg::*;

   localparam int unsigned ROM_AW          = 8;
   localparam int unsigned DEPTH           = 1 << ROM_AW;
   localparam int unsigned RESET_HOLD      = 250;
   localparam int unsigned POST_RESET_WAIT = 300;
   localparam int unsigned DELAY_UNIT      = 20;
   localparam int unsigned ACK_TIMEOUT     = 200;

   logic              xclk_cam = 1'b0;
   logic              reset_n  = 1'b0;
   logic              start_cfg = 1'b0;
   logic [1:0]        cam_sel  = 2'b00;
   logic [ROM_AW-1:0] rom_addr;
   logic [23:0]       rom_data;
   logic              sccb_start;
   logic [15:0]       sccb_address;
   logic [7:0]        sccb_data;
   logic              sccb_ready = 1'b1;
   logic [1:0]        select_initial_cam;
   logic              PWDN, RESETB, cfg_busy, cfg_done, cfg_error;
   logic [ROM_AW:0]   entries_done;

   ov5640_init_sequencer #(
      .ROM_AW          (ROM_AW),
      .RESET_HOLD      (RESET_HOLD),
      .POST_RESET_WAIT (POST_RESET_WAIT),
      .DELAY_UNIT      (DELAY_UNIT),
      .ACK_TIMEOUT     (ACK_TIMEOUT)
   ) dut (
      .xclk_cam           (xclk_cam),
      .reset_n            (reset_n),
      .start_cfg          (start_cfg),
      .cam_sel            (cam_sel),
      .rom_addr           (rom_addr),
      .rom_data           (rom_data),
      .sccb_start         (sccb_start),
      .sccb_address       (sccb_address),
      .sccb_data          (sccb_data),
      .sccb_ready         (sccb_ready),
      .select_initial_cam (select_initial_cam),
      .PWDN               (PWDN),
      .RESETB             (RESETB),
      .cfg_busy           (cfg_busy),
      .cfg_done           (cfg_done),
      .cfg_error          (cfg_error),
      .entries_done       (entries_done)
   );

   always #5 xclk_cam = ~xclk_cam;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Synchronous init ROM: data valid one cycle after address
   logic [23:0] rom [DEPTH];
   always @(posedge xclk_cam) rom_data <= rom[rom_addr];

   // Scoreboard of expected writes and cycle stamps of each sccb_start rise
   logic [23:0] exp_q[$];
   int          start_q[$];
   int          cyc = 0;
   logic        prev_start = 1'b0;

   always @(posedge xclk_cam) cyc++;

   always @(negedge xclk_cam) begin
      if (sccb_start && !prev_start) start_q.push_back(cyc);
      prev_start = sccb_start;
   end

   // Writer model: ready drops 4 cycles after start, returns 2 cycles after start drops
   int   wr_st = 0;
   int   wr_n  = 0;
   logic stuck = 1'b0;

   always @(negedge xclk_cam) begin
      if (!reset_n) begin
         wr_st = 0;
         sccb_ready = 1'b1;
      end else begin
         case (wr_st)
            0: if (sccb_start) begin
                  chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                  if (exp_q.size() != 0)
                     chk("wr_payload", {8'h00, sccb_address, sccb_data}, {8'h00, exp_q.pop_front()});
                  wr_n  = 0;
                  wr_st = stuck ? 4 : 1;
               end
            1: begin
                  wr_n++;
                  if (wr_n == 4) begin
                     sccb_ready = 1'b0;
                     wr_st = 2;
                  end
               end
            2: if (!sccb_start) begin
                  wr_n  = 0;
                  wr_st = 3;
               end
            3: begin
                  wr_n++;
                  if (wr_n == 2) begin
                     sccb_ready = 1'b1;
                     wr_st = 0;
                  end
               end
            default: if (!stuck) wr_st = 0;
         endcase
      end
   end

   function automatic logic probe(input int code);
      case (code)
         0:       return cfg_done;
         1:       return cfg_error;
         2:       return sccb_start;
         default: return RESETB;
      endcase
   endfunction

   // Counts negedges until the probed signal is high, bounded by limit
   task automatic wait_for(input int code, input int limit, input string tag, output int n);
      n = 0;
      while (!probe(code) && n < limit) begin
         @(negedge xclk_cam);
         n++;
      end
      chk(tag, 32'(probe(code)), 32'd1);
   endtask

   task automatic clear_table();
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = {REG_END, 8'h00};
      exp_q.delete();
      start_q.delete();
   endtask

   task automatic put(input int idx, input logic [23:0] e);
      rom[idx] = e;
      if (e[23:8] != REG_END && e[23:8] != REG_DELAY) exp_q.push_back(e);
   endtask

   task automatic pulse_start(input logic [1:0] sel);
      cam_sel   = sel;
      start_cfg = 1'b1;
      @(negedge xclk_cam);
      start_cfg = 1'b0;
   endtask

   initial begin
      int n;
      int g0;
      int g1;
      clear_table();
      repeat (3) @(negedge xclk_cam);

      // Reset state
      chk("rst_pwdn", PWDN, 1);
      chk("rst_resetb", RESETB, 0);
      chk("rst_start", sccb_start, 0);
      chk("rst_addr", sccb_address, 0);
      chk("rst_data", sccb_data, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_sel", select_initial_cam, 3);
      chk("rst_status", {cfg_busy, cfg_done, cfg_error}, 0);
      chk("rst_entries", entries_done, 0);
      reset_n = 1'b1;
      @(negedge xclk_cam);

      // Two writes, cam0, power timing
      clear_table();
      put(0, 24'h3012AA);
      put(1, 24'h3013BB);
      put(2, {REG_END, 8'h00});
      pulse_start(CAM0);
      chk("pwdn_low", PWDN, 0);
      chk("resetb_held", RESETB, 0);
      chk("busy_set", cfg_busy, 1);
      wait_for(3, RESET_HOLD + 10, "resetb_rise", n);
      chk("resetb_delay", n, RESET_HOLD);
      wait_for(2, POST_RESET_WAIT + 10, "first_start", n);
      chk("first_start_delay", n, POST_RESET_WAIT + 2);
      wait_for(0, 500, "t1_done", n);
      chk("t1_sel", select_initial_cam, 1);
      chk("t1_entries", entries_done, 2);
      chk("t1_status", {cfg_busy, cfg_done, cfg_error}, 3'b010);
      chk("t1_rom_addr", rom_addr, 2);
      chk("t1_sb_empty", exp_q.size(), 0);
      chk("t1_starts", start_q.size(), 2);
      g0 = start_q[1] - start_q[0];

      // Delay entry of 3 ticks between the same two writes
      clear_table();
      put(0, 24'h3012AA);
      put(1, {REG_DELAY, 8'h03});
      put(2, 24'h3013BB);
      put(3, {REG_END, 8'h00});
      pulse_start(CAM_BOTH);
      wait_for(0, RESET_HOLD + POST_RESET_WAIT + 3 * DELAY_UNIT + 500, "t2_done", n);
      g1 = start_q[1] - start_q[0];
      chk("delay_gap", g1 - g0, 3 * DELAY_UNIT + 3);
      chk("t2_sel", select_initial_cam, 0);
      chk("t2_entries", entries_done, 2);
      chk("t2_sb_empty", exp_q.size(), 0);

      // Writer never drops ready: handshake timeout
      clear_table();
      put(0, 24'h3012AA);
      put(1, {REG_END, 8'h00});
      stuck = 1'b1;
      pulse_start(CAM1);
      wait_for(2, RESET_HOLD + POST_RESET_WAIT + 20, "t3_start", n);
      wait_for(1, ACK_TIMEOUT + 20, "t3_error", n);
      chk("timeout_cycles", n, ACK_TIMEOUT + 1);
      chk("t3_start_low", sccb_start, 0);
      chk("t3_entries", entries_done, 0);
      chk("t3_status", {cfg_busy, cfg_done, cfg_error}, 3'b001);
      chk("t3_pins_hold", {PWDN, RESETB}, 2'b01);
      chk("t3_sel", select_initial_cam, 2);

      // Invalid camera select after a fresh reset
      reset_n = 1'b0;
      @(negedge xclk_cam);
      reset_n = 1'b1;
      stuck = 1'b0;
      @(negedge xclk_cam);
      clear_table();
      rom[0] = 24'h3012AA;
      pulse_start(CAM_NONE);
      chk("inv_error", cfg_error, 1);
      chk("inv_pins", {PWDN, RESETB}, 2'b10);
      chk("inv_busy", cfg_busy, 0);
      chk("inv_sel", select_initial_cam, 3);
      repeat (50) @(negedge xclk_cam);
      chk("inv_no_start", start_q.size(), 0);

      // Full table with no end marker
      clear_table();
      for (int i = 0; i < int'(DEPTH); i++) put(i, {16'h4000 + 16'(i), 8'(i) ^ 8'h5A});
      pulse_start(CAM0);
      wait_for(0, 20000, "t5_done", n);
      chk("full_entries", entries_done, DEPTH);
      chk("full_rom_addr", rom_addr, DEPTH - 1);
      chk("full_sb_empty", exp_q.size(), 0);
      chk("full_starts", start_q.size(), DEPTH);
      chk("full_error", cfg_error, 0);

      // Reset during ACK_LOW, then rerun from entry 0
      clear_table();
      put(0, 24'h3012AA);
      put(1, 24'h3013BB);
      put(2, {REG_END, 8'h00});
      pulse_start(CAM1);
      wait_for(2, RESET_HOLD + POST_RESET_WAIT + 20, "t6_start", n);
      @(negedge xclk_cam);
      chk("t6_start_before_rst", sccb_start, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_start", sccb_start, 0);
      chk("t6_rst_pins", {PWDN, RESETB}, 2'b10);
      chk("t6_rst_busy", cfg_busy, 0);
      chk("t6_rst_sel", select_initial_cam, 3);
      @(negedge xclk_cam);
      reset_n = 1'b1;
      exp_q.delete();
      start_q.delete();
      put(0, 24'h3012AA);
      put(1, 24'h3013BB);
      @(negedge xclk_cam);
      pulse_start(CAM1);
      wait_for(0, RESET_HOLD + POST_RESET_WAIT + 500, "t6_done", n);
      chk("t6_entries", entries_done, 2);
      chk("t6_sb_empty", exp_q.size(), 0);
      chk("t6_starts", start_q.size(), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ov5640_init_sequencer.md
# ov5640_init_sequencer

Power-up and register-table sequencer for the OV5640 camera pair. Drives PWDN/RESETB timing, walks an external synchronous init ROM of {address, data} entries, and feeds each write to the SCCB writer through a CDC-safe 4-phase start/ready handshake. Sits between the top-level control and the SCCB camera configuration block. It replaces ad-hoc start pulsing and decides which camera(s) receive the table.

## Interface
- ROM_AW, 8, ROM address width; table depth 2^ROM_AW entries
- RESET_HOLD, 2500, xclk_cam cycles RESETB held low after PWDN release
- POST_RESET_WAIT, 480000, cycles from RESETB high to first SCCB write (20 ms @ 24 MHz)
- DELAY_UNIT, 24000, cycles per delay-entry tick (1 ms @ 24 MHz)
- ACK_TIMEOUT, 65535, max cycles in any handshake wait before error
- xclk_cam  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start_cfg  in  1  single-cycle request to power up and configure
- cam_sel  in  2  target: 00 both, 01 cam0, 10 cam1, 11 invalid
- rom_addr  out  ROM_AW  init ROM address
- rom_data  in  24  {reg_addr[15:0], reg_data[7:0]}, valid 1 cycle after rom_addr
- sccb_start  out  1  write request level to SCCB writer
- sccb_address  out  16  register address, stable while handshake open
- sccb_data  out  8  register data, stable while handshake open
- sccb_ready  in  1  writer idle flag, clk_sys domain (asynchronous here)
- select_initial_cam  out  2  camera select to SCCB block
- PWDN  out  1  camera power-down, both cameras
- RESETB  out  1  camera reset, active-low, both cameras
- cfg_busy / cfg_done / cfg_error  out  1 each  status levels
- entries_done  out  ROM_AW+1  count of completed register writes

## Operation
- Reset values: PWDN=1, RESETB=0, sccb_start=0, sccb_address=0, sccb_data=0, rom_addr=0, select_initial_cam=2'b11, cfg_busy=0, cfg_done=0, cfg_error=0, entries_done=0; state IDLE.
- States: IDLE, RST_HOLD, POST_WAIT, FETCH, DECODE, REQ, ACK_LOW, ACK_HIGH, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + start_cfg: cam_sel==11 -> ERROR (cfg_error=1, no pin activity); else latch cam_sel into select_initial_cam, clear done/error/entries_done/rom_addr, PWDN=0, RESETB=0, busy=1 -> RST_HOLD. start_cfg ignored in all other states.
- RST_HOLD: count RESET_HOLD cycles, then RESETB=1 -> POST_WAIT.
- POST_WAIT: count POST_RESET_WAIT cycles -> FETCH.
- FETCH: rom_addr presented -> DECODE next cycle samples rom_data.
- DECODE: reg_addr 16'hFFFE -> DONE; 16'hFFFF -> DELAY with reg_data ticks (0 = no wait, advance); otherwise load sccb_address/sccb_data -> REQ.
- REQ: sccb_start=1 -> ACK_LOW. ACK_LOW: wait synced ready==0, then sccb_start=0 -> ACK_HIGH. ACK_HIGH: wait synced ready==1, entries_done+1, advance.
- Advance: rom_addr==2^ROM_AW-1 -> DONE (no wrap); else rom_addr+1 -> FETCH.
- DELAY: nested counters (unit counter 0..DELAY_UNIT-1, tick counter 8 bit); advance after reg_data ticks.
- ACK_LOW or ACK_HIGH exceeding ACK_TIMEOUT cycles -> ERROR, sccb_start=0.
- DONE: busy=0, done=1. ERROR: busy=0, error=1; PWDN/RESETB hold current values.
- reset_n low mid-operation: all outputs to reset values immediately, sccb_start drops asynchronously.

## Timing
- sccb_ready passes a 2-flop synchronizer; handshake decisions use the synced value (2-3 cycle latency).
- start_cfg sampled -> PWDN low next edge; RESETB rises RESET_HOLD cycles later; first sccb_start rises POST_RESET_WAIT+2 cycles after RESETB.
- Per-entry overhead outside handshake waits: FETCH + DECODE + REQ = 3 cycles.
- sccb_address/sccb_data change only in DECODE; constant from REQ through ACK_HIGH.
- Timeout counter clears on every state entry.

## Structure
- Package ov5640_cfg_pkg: state enum, REG_END=16'hFFFE, REG_DELAY=16'hFFFF, CAM_BOTH/CAM0/CAM1/CAM_NONE constants.
- Sub-module sync_2ff (1-bit, async reset to 0) for sccb_ready.

## Test plan
- Table {3012:AA, 3013:BB, FFFE:00}, cam_sel=01, writer model ready drops 4 cycles after start -> two writes in order, select_initial_cam=01, entries_done=2, cfg_done=1.
- Power timing: start_cfg -> PWDN low next cycle, RESETB high after exactly 2500 cycles, first sccb_start 480002 cycles later.
- Delay entry FFFF:03 between two writes -> 72000-cycle gap (+overhead) between handshakes.
- Writer holds ready high forever -> cfg_error after 65535 cycles, sccb_start=0, entries_done unchanged.
- cam_sel=11 -> cfg_error=1, PWDN stays 1, no sccb_start; full table without FFFE -> DONE after 256 writes, rom_addr stops at 255.
- reset_n asserted during ACK_LOW -> sccb_start=0, PWDN=1, RESETB=0 same cycle; new start_cfg reruns from entry 0.
